// File: rtl/fetch_queue.sv
// Show-ahead instruction fetch queue: buffers {pc, inst} pairs between fetch and
// dispatch, with a head entry that is always visible and a mispredict flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          enq_valid_i,
    input  logic [31:0]   enq_pc_i,
    input  logic [31:0]   enq_inst_i,
    output logic          enq_ready_o,
    output logic          deq_valid_o,
    input  logic          deq_ready_i,
    output logic [31:0]   deq_pc_o,
    output logic [31:0]   deq_pc4_o,
    output logic [31:0]   deq_inst_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [AW:0]   occ;
    logic          empty, full;
    logic          do_enq, do_deq;
    entry_t        head;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign occ    = wr_ptr_q - rd_ptr_q;

    assign do_enq = enq_valid_i && !full;
    assign do_deq = deq_ready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_enq && !flush_i) begin
            mem_q[wr_idx].pc   <= enq_pc_i;
            mem_q[wr_idx].inst <= enq_inst_i;
        end
    end

    assign head        = empty ? '0 : mem_q[rd_idx];
    assign deq_pc_o    = head.pc;
    assign deq_inst_o  = head.inst;
    assign deq_pc4_o   = head.pc + 32'd4;
    assign enq_ready_o = !full;
    assign deq_valid_o = !empty;
    assign count_o     = CW'(occ);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          enq_valid;
    logic [31:0]   enq_pc;
    logic [31:0]   enq_inst;
    logic          enq_ready;
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_pc;
    logic [31:0]   deq_pc4;
    logic [31:0]   deq_inst;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_pc_i(enq_pc), .enq_inst_i(enq_inst),
        .enq_ready_o(enq_ready), .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
        .deq_pc_o(deq_pc), .deq_pc4_o(deq_pc4), .deq_inst_o(deq_inst), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    bit   enq_acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: a plain queue, updated with the inputs seen at each edge.
    task automatic model_edge();
        bit do_deq, do_enq;
        enq_acc = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            do_deq = deq_ready && (q.size() > 0);
            do_enq = enq_valid && (q.size() < DEPTH);
            if (do_deq) void'(q.pop_front());
            if (do_enq) begin
                q.push_back('{enq_pc, enq_inst});
                enq_acc = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [31:0] epc, einst;
        epc   = (q.size() > 0) ? q[0].pc   : 32'h0;
        einst = (q.size() > 0) ? q[0].inst : 32'h0;
        check("m_count",     32'(count),     32'(q.size()));
        check("m_enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
        check("m_deq_valid", 32'(deq_valid), 32'(q.size() > 0));
        check("m_deq_pc",    deq_pc,         epc);
        check("m_deq_pc4",   deq_pc4,        epc + 32'd4);
        check("m_deq_inst",  deq_inst,       einst);
    end

    task automatic idle_inputs();
        flush = 0; enq_valid = 0; deq_ready = 0; enq_pc = 0; enq_inst = 0;
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] cur_inst;
        rst_n = 0;
        idle_inputs();
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_enq_ready", 32'(enq_ready), 1);
        check("rst_deq_valid", 32'(deq_valid), 0);
        check("rst_deq_inst", deq_inst, 0);
        check("rst_deq_pc", deq_pc, 0);
        check("rst_deq_pc4", deq_pc4, 32'h4);
        rst_n = 1;
        tick();

        // Fill to full with deq_ready low.
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1; enq_pc = 32'(4 * i); enq_inst = 32'hA0 + 32'(i);
            tick();
        end
        check("full_count", 32'(count), 4);
        check("full_enq_ready", 32'(enq_ready), 0);
        check("full_deq_pc", deq_pc, 0);
        check("full_deq_inst", deq_inst, 32'hA0);

        // From full: deq + enq pc=10; only the deq happens this edge.
        enq_valid = 1; enq_pc = 32'h10; enq_inst = 32'hA4; deq_ready = 1;
        tick();
        check("fulldeq_count", 32'(count), 3);
        check("fulldeq_head", deq_pc, 32'h4);
        deq_ready = 0;
        tick();
        check("reopen_count", 32'(count), 4);
        enq_valid = 0; deq_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("order_pc", deq_pc, 32'h4 + 32'(4 * i));
            tick();
        end
        check("drained_count", 32'(count), 0);

        // Streaming at occupancy 2 across pointer wrap.
        deq_ready = 0;
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1; enq_pc = 32'h100 + 32'(4 * i); enq_inst = 32'hB00 + 32'(i);
            tick();
        end
        deq_ready = 1;
        for (int i = 0; i < 10; i++) begin
            enq_pc = 32'h108 + 32'(4 * i); enq_inst = 32'hB02 + 32'(i);
            check("stream_head", deq_pc, 32'h100 + 32'(4 * i));
            tick();
            check("stream_count", 32'(count), 2);
        end

        // Flush with concurrent enq and deq at count=3.
        deq_ready = 0; enq_pc = 32'h200; enq_inst = 32'hC0;
        tick();
        check("preflush_count", 32'(count), 3);
        flush = 1; enq_valid = 1; deq_ready = 1; enq_pc = 32'h204; enq_inst = 32'hC1;
        tick();
        check("flush_count", 32'(count), 0);
        check("flush_deq_valid", 32'(deq_valid), 0);
        check("flush_deq_inst", deq_inst, 0);
        idle_inputs();
        tick();
        check("flush_absent", 32'(count), 0);

        // Empty with deq_ready held: single enq becomes visible one cycle later.
        deq_ready = 1; enq_valid = 1; enq_pc = 32'h40; enq_inst = 32'hD0;
        check("bypass_none", 32'(deq_valid), 0);
        tick();
        enq_valid = 0;
        check("single_valid", 32'(deq_valid), 1);
        check("single_pc", deq_pc, 32'h40);
        check("single_pc4", deq_pc4, 32'h44);
        tick();
        check("single_consumed", 32'(deq_valid), 0);

        // Asynchronous reset mid-stream.
        deq_ready = 0; enq_valid = 1;
        for (int i = 0; i < 3; i++) begin
            enq_pc = 32'h300 + 32'(4 * i); enq_inst = 32'hE0 + 32'(i);
            tick();
        end
        #1;
        rst_n = 0;
        q.delete();
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_enq_ready", 32'(enq_ready), 1);
        check("arst_deq_valid", 32'(deq_valid), 0);
        check("arst_deq_pc4", deq_pc4, 32'h4);
        idle_inputs();
        tick();
        rst_n = 1;
        tick();

        // Randomized run; the fetch side holds a word until it is accepted.
        cur_pc = 32'h1000; cur_inst = $urandom;
        for (int c = 0; c < 3000; c++) begin
            flush     = ($urandom_range(0, 99) < 3);
            deq_ready = ($urandom_range(0, 99) < 55);
            if (!enq_valid || enq_acc || flush)
                enq_valid = ($urandom_range(0, 99) < 70);
            enq_pc = cur_pc; enq_inst = cur_inst;
            tick();
            if (flush) begin
                cur_pc = {$urandom_range(0, 32'h3FFF), 2'b00}; cur_inst = $urandom;
                enq_valid = 0;
            end else if (enq_acc) begin
                cur_pc = cur_pc + 32'd4; cur_inst = $urandom;
            end
        end

        idle_inputs();
        #2;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
